// File: rtl/reg_trigger_bank_if.sv
// Register-bus interface for reg_trigger_bank.
// Bus protocol: the host holds reg_address/reg_bytecnt/write_data stable while
// it asserts a reg_write or reg_read strobe, qualified by reg_addrvalid, for
// exactly one cycle per byte. There is no backpressure: every strobed write is
// taken on that clock edge. read_data is valid the cycle after the reg_read
// strobe and holds until the next selected read.
interface reg_trigger_bank_if #(
  parameter int pBYTECNT_SIZE = 7
) ();
  logic [7:0]               reg_address;
  logic [pBYTECNT_SIZE-1:0] reg_bytecnt;
  logic [7:0]               write_data;
  logic [7:0]               read_data;
  logic                     reg_read;
  logic                     reg_write;
  logic                     reg_addrvalid;
  logic                     selected;

  modport master (
    output reg_address, reg_bytecnt, write_data, reg_read, reg_write, reg_addrvalid,
    input  read_data, selected
  );

  modport slave (
    input  reg_address, reg_bytecnt, write_data, reg_read, reg_write, reg_addrvalid,
    output read_data, selected
  );
endinterface

// File: rtl/reg_trigger_bank.sv
// Multi-channel, multi-pulse trigger timing bank on the USB register bus.
// Host writes byte-wise shadow registers; a commit copies every shadow to the
// active outputs in a single cycle, deferred while the trigger generator is
// busy. Also hosts a multi-step trigger-clock phase-shift sequencer.
// Optional feature macro: REG_TRIGGER_BANK_PS_TIMEOUT_EN adds a timeout on the
// psdone wait with a sticky status bit.
module reg_trigger_bank #(
  parameter int         pBYTECNT_SIZE    = 7,
  parameter int         pNUM_CHANNELS    = 2,
  parameter int         pNUM_PULSES      = 8,
  parameter int         pPULSE_SEL_WIDTH = 3,
  parameter int         pTIME_WIDTH      = 24,
  parameter logic [2:0] pSELECT          = 3'b011,
  parameter int         pPS_TIMEOUT      = 1023
) (
  input  logic                                          cwusb_clk,
  input  logic                                          reset_i,
  reg_trigger_bank_if.slave                             bus,
  input  logic                                          I_trig_busy,
  output logic [pNUM_CHANNELS*pNUM_PULSES*pTIME_WIDTH-1:0] O_trigger_delay,
  output logic [pNUM_CHANNELS*pNUM_PULSES*pTIME_WIDTH-1:0] O_trigger_width,
  output logic [pNUM_CHANNELS*4-1:0]                    O_num_pulses,
  output logic [pNUM_CHANNELS-1:0]                      O_chan_enable,
  output logic                                          O_commit_pulse,
  output logic                                          O_psen,
  output logic                                          O_psincdec,
  input  logic                                          I_psdone,
  output logic [1:0]                                    ps_state
);

  localparam int CW     = (pNUM_CHANNELS > 1) ? $clog2(pNUM_CHANNELS) : 1;
  localparam int PW     = pPULSE_SEL_WIDTH;
  localparam int TBYTES = pTIME_WIDTH / 8;
  localparam int BW     = (TBYTES > 1) ? $clog2(TBYTES) : 1;
  localparam int FLAT   = pNUM_CHANNELS * pNUM_PULSES * pTIME_WIDTH;
  localparam int TOW    = $clog2(pPS_TIMEOUT + 1);

`ifdef REG_TRIGGER_BANK_PS_TIMEOUT_EN
  localparam bit PS_TIMEOUT_EN = 1'b1;
`else
  localparam bit PS_TIMEOUT_EN = 1'b0;
`endif

  localparam logic [4:0] A_CHAN      = 5'h00;
  localparam logic [4:0] A_PULSE     = 5'h01;
  localparam logic [4:0] A_DELAY     = 5'h02;
  localparam logic [4:0] A_WIDTH     = 5'h03;
  localparam logic [4:0] A_NUM       = 5'h04;
  localparam logic [4:0] A_ENABLE    = 5'h05;
  localparam logic [4:0] A_COMMIT    = 5'h06;
  localparam logic [4:0] A_PS_STEPS  = 5'h07;
  localparam logic [4:0] A_PS_STATUS = 5'h08;

  typedef enum logic [1:0] {
    PS_IDLE  = 2'd0,
    PS_ISSUE = 2'd1,
    PS_WAIT  = 2'd2
  } ps_state_t;

  // Address decode and index qualification
  logic [4:0]    sub;
  logic          sel;
  logic          wr_en;
  logic          byte0, byte1, byte2;
  logic [7:0]    chan_sel, pulse_sel;
  logic          chan_ok, pulse_ok, byte_ok;
  logic [CW-1:0] chan_idx;
  logic [PW-1:0] pulse_idx;
  logic [BW-1:0] byte_idx;

  assign sub          = bus.reg_address[4:0];
  assign sel          = bus.reg_addrvalid && (bus.reg_address[7:5] == pSELECT);
  assign bus.selected = sel;
  assign wr_en        = sel && bus.reg_write;
  assign byte0        = (bus.reg_bytecnt == pBYTECNT_SIZE'(0));
  assign byte1        = (bus.reg_bytecnt == pBYTECNT_SIZE'(1));
  assign byte2        = (bus.reg_bytecnt == pBYTECNT_SIZE'(2));
  assign chan_ok      = (chan_sel < 8'(pNUM_CHANNELS));
  assign pulse_ok     = (pulse_sel < 8'(pNUM_PULSES));
  assign byte_ok      = (bus.reg_bytecnt < pBYTECNT_SIZE'(TBYTES));
  assign chan_idx     = chan_sel[CW-1:0];
  assign pulse_idx    = pulse_sel[PW-1:0];
  assign byte_idx     = bus.reg_bytecnt[BW-1:0];

  // Shadow storage, kept as bytes so host writes need no bit arithmetic
  logic [7:0]               sh_delay [pNUM_CHANNELS][pNUM_PULSES][TBYTES];
  logic [7:0]               sh_width [pNUM_CHANNELS][pNUM_PULSES][TBYTES];
  logic [3:0]               sh_num   [pNUM_CHANNELS];
  logic [pNUM_CHANNELS-1:0] sh_en;
  logic [FLAT-1:0]          sh_delay_flat, sh_width_flat;
  logic [pNUM_CHANNELS*4-1:0] sh_num_flat;

  logic       pending;
  logic       apply;
  logic       commit_wr;

  ps_state_t  ps_st;
  logic [15:0] ps_count;
  logic [15:0] ps_step_next;
  logic [7:0]  ps_lo;
  logic        ps_wr;
  logic        ps_active;
  logic        ps_timeout;
  logic [TOW-1:0] wait_cnt;
  logic [7:0]  rd_mux;

  assign commit_wr    = wr_en && (sub == A_COMMIT) && byte0;
  assign apply        = pending && !I_trig_busy;
  assign ps_wr        = wr_en && (sub == A_PS_STEPS);
  assign ps_step_next = ps_count[15] ? (ps_count + 16'd1) : (ps_count - 16'd1);
  assign ps_active    = (ps_st != PS_IDLE) || (ps_count != 16'd0);
  assign ps_state     = ps_st;

  // Flatten shadows into the channel-major output layout
  always_comb begin
    sh_delay_flat = '0;
    sh_width_flat = '0;
    sh_num_flat   = '0;
    for (int c = 0; c < pNUM_CHANNELS; c++) begin
      sh_num_flat[c*4 +: 4] = sh_num[c];
      for (int p = 0; p < pNUM_PULSES; p++) begin
        for (int b = 0; b < TBYTES; b++) begin
          sh_delay_flat[((c*pNUM_PULSES + p)*TBYTES + b)*8 +: 8] = sh_delay[c][p][b];
          sh_width_flat[((c*pNUM_PULSES + p)*TBYTES + b)*8 +: 8] = sh_width[c][p][b];
        end
      end
    end
  end

  // Host writes into index registers and shadows
  always_ff @(posedge cwusb_clk or negedge reset_i) begin
    if (!reset_i) begin
      chan_sel  <= '0;
      pulse_sel <= '0;
      sh_en     <= '0;
      for (int c = 0; c < pNUM_CHANNELS; c++) begin
        sh_num[c] <= '0;
        for (int p = 0; p < pNUM_PULSES; p++) begin
          for (int b = 0; b < TBYTES; b++) begin
            sh_delay[c][p][b] <= '0;
            sh_width[c][p][b] <= '0;
          end
        end
      end
    end else if (wr_en) begin
      case (sub)
        A_CHAN:   if (byte0) chan_sel <= bus.write_data;
        A_PULSE:  if (byte0) pulse_sel <= bus.write_data;
        A_DELAY:  if (chan_ok && pulse_ok && byte_ok) sh_delay[chan_idx][pulse_idx][byte_idx] <= bus.write_data;
        A_WIDTH:  if (chan_ok && pulse_ok && byte_ok) sh_width[chan_idx][pulse_idx][byte_idx] <= bus.write_data;
        A_NUM:    if (byte0 && chan_ok) sh_num[chan_idx] <= bus.write_data[3:0];
        A_ENABLE: if (byte0) sh_en <= bus.write_data[pNUM_CHANNELS-1:0];
        default:  ;
      endcase
    end
  end

  // Commit: pending flag, atomic shadow-to-active copy and strobe.
  // A commit write landing on the apply cycle does not re-arm pending, so a
  // repeated request while one is outstanding yields a single commit.
  always_ff @(posedge cwusb_clk or negedge reset_i) begin
    if (!reset_i) begin
      pending         <= 1'b0;
      O_commit_pulse  <= 1'b0;
      O_trigger_delay <= '0;
      O_trigger_width <= '0;
      O_num_pulses    <= {pNUM_CHANNELS{4'd1}};
      O_chan_enable   <= '0;
    end else begin
      O_commit_pulse <= apply;
      if (apply) begin
        O_trigger_delay <= sh_delay_flat;
        O_trigger_width <= sh_width_flat;
        O_num_pulses    <= sh_num_flat;
        O_chan_enable   <= sh_en;
      end
      if (commit_wr) pending <= bus.write_data[0] && !apply;
      else if (apply) pending <= 1'b0;
    end
  end

  // Phase-shift sequencer: one psen per step, stepping the count toward zero
  always_ff @(posedge cwusb_clk or negedge reset_i) begin
    if (!reset_i) begin
      ps_st      <= PS_IDLE;
      ps_count   <= '0;
      ps_lo      <= '0;
      O_psen     <= 1'b0;
      O_psincdec <= 1'b0;
      ps_timeout <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      O_psen <= 1'b0;
      if (wr_en && (sub == A_PS_STATUS)) ps_timeout <= 1'b0;
      case (ps_st)
        PS_IDLE: begin
          if (ps_count != 16'd0) begin
            ps_st      <= PS_ISSUE;
            O_psen     <= 1'b1;
            O_psincdec <= !ps_count[15];
          end else if (ps_wr && byte0) begin
            ps_lo <= bus.write_data;
          end else if (ps_wr && byte1) begin
            ps_count <= {bus.write_data, ps_lo};
          end
        end
        PS_ISSUE: begin
          ps_st    <= PS_WAIT;
          wait_cnt <= '0;
        end
        PS_WAIT: begin
          if (I_psdone) begin
            ps_count <= ps_step_next;
            if (ps_step_next != 16'd0) begin
              ps_st      <= PS_ISSUE;
              O_psen     <= 1'b1;
              O_psincdec <= !ps_step_next[15];
            end else begin
              ps_st <= PS_IDLE;
            end
          end else if (PS_TIMEOUT_EN && (wait_cnt == TOW'(pPS_TIMEOUT - 1))) begin
            ps_st      <= PS_IDLE;
            ps_count   <= '0;
            ps_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: ps_st <= PS_IDLE;
      endcase
    end
  end

  // Read mux over the current register state
  always_comb begin
    rd_mux = 8'h00;
    case (sub)
      A_CHAN:      if (byte0) rd_mux = chan_sel;
      A_PULSE:     if (byte0) rd_mux = pulse_sel;
      A_DELAY:     if (chan_ok && pulse_ok && byte_ok) rd_mux = sh_delay[chan_idx][pulse_idx][byte_idx];
      A_WIDTH:     if (chan_ok && pulse_ok && byte_ok) rd_mux = sh_width[chan_idx][pulse_idx][byte_idx];
      A_NUM:       if (byte0 && chan_ok) rd_mux = {4'b0, sh_num[chan_idx]};
      A_ENABLE:    if (byte0) rd_mux = 8'(sh_en);
      A_COMMIT:    if (byte0) rd_mux = {6'b0, I_trig_busy, pending};
      A_PS_STEPS: begin
        if (byte0) rd_mux = ps_count[7:0];
        else if (byte1) rd_mux = ps_count[15:8];
      end
      A_PS_STATUS: begin
        if (byte0) rd_mux = {6'b0, ps_timeout, ps_active};
        else if (byte1) rd_mux = ps_count[7:0];
        else if (byte2) rd_mux = ps_count[15:8];
      end
      default: rd_mux = 8'h00;
    endcase
  end

  // Registered read data, updated on each selected read strobe
  always_ff @(posedge cwusb_clk or negedge reset_i) begin
    if (!reset_i) bus.read_data <= 8'h00;
    else if (sel && bus.reg_read) bus.read_data <= rd_mux;
  end

endmodule

// File: tb/tb_reg_trigger_bank.sv
// Directed plus randomized bench for reg_trigger_bank.
`timescale 1ns/1ps
module tb_reg_trigger_bank;
  localparam int NC   = 2;
  localparam int NP   = 8;
  localparam int TW   = 24;
  localparam int TB   = 3;
  localparam int FLAT = NC*NP*TW;
  localparam int TO   = 1023;
  localparam int IDX12 = (1*NP + 2)*TW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic trig_busy = 1'b0;
  logic psdone = 1'b0;
  logic [FLAT-1:0] o_delay, o_width;
  logic [NC*4-1:0] o_num;
  logic [NC-1:0]   o_en;
  logic o_commit, o_psen, o_psincdec;
  logic [1:0] ps_state;

  int checks = 0;
  int errors = 0;

  reg_trigger_bank_if #(.pBYTECNT_SIZE(7)) bus ();

  reg_trigger_bank dut (
    .cwusb_clk       (clk),
    .reset_i         (rst_n),
    .bus             (bus),
    .I_trig_busy     (trig_busy),
    .O_trigger_delay (o_delay),
    .O_trigger_width (o_width),
    .O_num_pulses    (o_num),
    .O_chan_enable   (o_en),
    .O_commit_pulse  (o_commit),
    .O_psen          (o_psen),
    .O_psincdec      (o_psincdec),
    .I_psdone        (psdone),
    .ps_state        (ps_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Reference model: shadow and active register images
  logic [TW-1:0] m_sd [NC][NP];
  logic [TW-1:0] m_sw [NC][NP];
  logic [TW-1:0] m_ad [NC][NP];
  logic [TW-1:0] m_aw [NC][NP];
  logic [3:0]    m_sn [NC];
  logic [3:0]    m_an [NC];
  logic [NC-1:0] m_se, m_ae;
  int m_chan, m_pulse;

  function automatic logic [TW-1:0] put_byte(input logic [TW-1:0] v, input int b, input logic [7:0] d);
    logic [TW-1:0] mask;
    mask = TW'(8'hFF) << (8*b);
    return (v & ~mask) | (TW'(d) << (8*b));
  endfunction

  function automatic void m_write(input logic [4:0] sub, input int b, input logic [7:0] d);
    case (sub)
      5'h00: if (b == 0) m_chan = int'(d);
      5'h01: if (b == 0) m_pulse = int'(d);
      5'h02: if (m_chan < NC && m_pulse < NP && b < TB) m_sd[m_chan][m_pulse] = put_byte(m_sd[m_chan][m_pulse], b, d);
      5'h03: if (m_chan < NC && m_pulse < NP && b < TB) m_sw[m_chan][m_pulse] = put_byte(m_sw[m_chan][m_pulse], b, d);
      5'h04: if (b == 0 && m_chan < NC) m_sn[m_chan] = d[3:0];
      5'h05: if (b == 0) m_se = d[NC-1:0];
      default: ;
    endcase
  endfunction

  function automatic logic [7:0] m_read(input logic [4:0] sub, input int b);
    logic [7:0] r;
    r = 8'h00;
    case (sub)
      5'h00: if (b == 0) r = 8'(m_chan);
      5'h01: if (b == 0) r = 8'(m_pulse);
      5'h02: if (m_chan < NC && m_pulse < NP && b < TB) r = 8'(m_sd[m_chan][m_pulse] >> (8*b));
      5'h03: if (m_chan < NC && m_pulse < NP && b < TB) r = 8'(m_sw[m_chan][m_pulse] >> (8*b));
      5'h04: if (b == 0 && m_chan < NC) r = {4'b0, m_sn[m_chan]};
      5'h05: if (b == 0) r = 8'(m_se);
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic void m_commit();
    for (int c = 0; c < NC; c++) begin
      m_an[c] = m_sn[c];
      for (int p = 0; p < NP; p++) begin
        m_ad[c][p] = m_sd[c][p];
        m_aw[c][p] = m_sw[c][p];
      end
    end
    m_ae = m_se;
  endfunction

  function automatic logic [FLAT-1:0] exp_flat(input bit want_width);
    logic [FLAT-1:0] r;
    r = '0;
    for (int c = 0; c < NC; c++)
      for (int p = 0; p < NP; p++)
        r[(c*NP + p)*TW +: TW] = want_width ? m_aw[c][p] : m_ad[c][p];
    return r;
  endfunction

  function automatic logic [NC*4-1:0] exp_num();
    logic [NC*4-1:0] r;
    for (int c = 0; c < NC; c++) r[c*4 +: 4] = m_an[c];
    return r;
  endfunction

  // Scoreboard comparison
  task automatic check(input string tag, input logic [FLAT-1:0] obs, input logic [FLAT-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_delay"}, o_delay, exp_flat(1'b0));
    check({tag, "_width"}, o_width, exp_flat(1'b1));
    check({tag, "_num"}, FLAT'(o_num), FLAT'(exp_num()));
    check({tag, "_en"}, FLAT'(o_en), FLAT'(m_ae));
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_raw(input logic [7:0] addr, input int b, input logic [7:0] d);
    bus.reg_address   = addr;
    bus.reg_bytecnt   = 7'(b);
    bus.write_data    = d;
    bus.reg_addrvalid = 1'b1;
    bus.reg_write     = 1'b1;
    tick();
    bus.reg_write     = 1'b0;
    bus.reg_addrvalid = 1'b0;
  endtask

  task automatic wr(input logic [4:0] sub, input int b, input logic [7:0] d);
    wr_raw({3'b011, sub}, b, d);
    m_write(sub, b, d);
  endtask

  task automatic rd(input logic [4:0] sub, input int b, output logic [7:0] d);
    bus.reg_address   = {3'b011, sub};
    bus.reg_bytecnt   = 7'(b);
    bus.reg_addrvalid = 1'b1;
    bus.reg_read      = 1'b1;
    tick();
    bus.reg_read      = 1'b0;
    bus.reg_addrvalid = 1'b0;
    d = bus.read_data;
  endtask

  // Stimulus sequence
  initial begin
    logic [7:0] d;
    int n, dly, cyc, ncommit;
    logic [4:0] rsub;
    int rb, rc, rp;

    bus.reg_address = '0; bus.reg_bytecnt = '0; bus.write_data = '0;
    bus.reg_read = 1'b0; bus.reg_write = 1'b0; bus.reg_addrvalid = 1'b0;
    m_chan = 0; m_pulse = 0; m_se = '0; m_ae = '0;
    for (int c = 0; c < NC; c++) begin
      m_sn[c] = 4'd0; m_an[c] = 4'd1;
      for (int p = 0; p < NP; p++) begin
        m_sd[c][p] = '0; m_sw[c][p] = '0; m_ad[c][p] = '0; m_aw[c][p] = '0;
      end
    end

    // Reset held for three cycles
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    check_outputs("reset");
    check("reset_psen", FLAT'(o_psen), FLAT'(1'b0));
    check("reset_commit", FLAT'(o_commit), FLAT'(1'b0));
    check("reset_rdata", FLAT'(bus.read_data), FLAT'(8'h00));

    // Address window decode
    bus.reg_addrvalid = 1'b1; bus.reg_address = 8'h62; #1;
    check("selected_in", FLAT'(bus.selected), FLAT'(1'b1));
    bus.reg_address = 8'h42; #1;
    check("selected_out", FLAT'(bus.selected), FLAT'(1'b0));
    bus.reg_addrvalid = 1'b0; #1;
    check("selected_novalid", FLAT'(bus.selected), FLAT'(1'b0));
    tick();

    // Shadow write then commit with busy low
    wr(5'h00, 0, 8'd1); wr(5'h01, 0, 8'd2);
    wr(5'h02, 0, 8'h56); wr(5'h02, 1, 8'h34); wr(5'h02, 2, 8'h12);
    check_outputs("pre_commit");
    wr(5'h06, 0, 8'h01);
    check("commit_cycle1", FLAT'(o_commit), FLAT'(1'b0));
    tick();
    m_commit();
    check("commit_cycle2", FLAT'(o_commit), FLAT'(1'b1));
    check("commit_ch1p2", FLAT'(o_delay[IDX12 +: TW]), FLAT'(24'h123456));
    check_outputs("commit");
    tick();
    check("commit_single", FLAT'(o_commit), FLAT'(1'b0));

    // Commit deferred by busy
    trig_busy = 1'b1;
    wr(5'h03, 0, 8'hA5);
    wr(5'h06, 0, 8'h01);
    repeat (3) tick();
    check_outputs("busy_hold");
    rd(5'h06, 0, d);
    check("busy_status", FLAT'(d), FLAT'(8'h03));
    trig_busy = 1'b0;
    tick();
    m_commit();
    check("busy_release_pulse", FLAT'(o_commit), FLAT'(1'b1));
    check_outputs("busy_release");
    rd(5'h06, 0, d);
    check("busy_cleared", FLAT'(d), FLAT'(8'h00));

    // Repeated commit while pending gives one commit; cancel gives none
    trig_busy = 1'b1;
    wr(5'h06, 0, 8'h01); wr(5'h06, 0, 8'h01);
    trig_busy = 1'b0;
    ncommit = 0;
    for (int i = 0; i < 6; i++) begin tick(); if (o_commit) ncommit++; end
    check("no_extra_commit", FLAT'(ncommit), FLAT'(1));
    trig_busy = 1'b1;
    wr(5'h06, 0, 8'h01); wr(5'h06, 0, 8'h00);
    trig_busy = 1'b0;
    ncommit = 0;
    for (int i = 0; i < 6; i++) begin tick(); if (o_commit) ncommit++; end
    check("cancel_commit", FLAT'(ncommit), FLAT'(0));

    // Apply coinciding with a shadow write takes the pre-write value
    trig_busy = 1'b1;
    wr(5'h02, 0, 8'h99);
    wr(5'h06, 0, 8'h01);
    trig_busy = 1'b0;
    m_commit();
    wr(5'h02, 0, 8'h11);
    check("coincide_pulse", FLAT'(o_commit), FLAT'(1'b1));
    check_outputs("coincide");
    wr(5'h06, 0, 8'h01); tick(); m_commit();
    check_outputs("coincide_after");

    // Phase shift of -3 steps, psdone four cycles after each psen
    wr(5'h07, 0, 8'hFD); wr(5'h07, 1, 8'hFF);
    rd(5'h08, 0, d);
    check("ps_neg_active", FLAT'(d), FLAT'(8'h01));
    n = 0; dly = -1;
    for (int i = 0; i < 200; i++) begin
      psdone = 1'b0;
      if (o_psen) begin
        n++; dly = 4;
        check("ps_neg_dir", FLAT'(o_psincdec), FLAT'(1'b0));
      end else if (dly > 0) begin
        dly--;
        if (dly == 0) psdone = 1'b1;
      end
      tick();
    end
    psdone = 1'b0;
    check("ps_neg_count", FLAT'(n), FLAT'(3));
    rd(5'h08, 0, d);
    check("ps_neg_idle", FLAT'(d), FLAT'(8'h00));
    rd(5'h08, 1, d);
    check("ps_neg_remain", FLAT'(d), FLAT'(8'h00));

    // Phase shift of +2 steps, second write mid-sequence, no psdone ever
    wr(5'h07, 0, 8'h02); wr(5'h07, 1, 8'h00);
    n = 0; cyc = 0;
    while (!o_psen && cyc < 20) begin tick(); cyc++; end
    check("ps_pos_first", FLAT'(o_psen), FLAT'(1'b1));
    check("ps_pos_dir", FLAT'(o_psincdec), FLAT'(1'b1));
    if (o_psen) n++;
    tick();
    wr(5'h07, 0, 8'h05); wr(5'h07, 1, 8'h00);
`ifdef REG_TRIGGER_BANK_PS_TIMEOUT_EN
    for (int i = 0; i < TO + 40; i++) begin if (o_psen) n++; tick(); end
    check("ps_pos_psen", FLAT'(n), FLAT'(1));
    rd(5'h08, 0, d);
    check("ps_timeout_status", FLAT'(d), FLAT'(8'h02));
    rd(5'h08, 1, d);
    check("ps_timeout_remain", FLAT'(d), FLAT'(8'h00));
    wr_raw(8'h68, 0, 8'h00);
    rd(5'h08, 0, d);
    check("ps_timeout_clear", FLAT'(d), FLAT'(8'h00));
`else
    for (int i = 0; i < 80; i++) begin if (o_psen) n++; tick(); end
    check("ps_pos_psen", FLAT'(n), FLAT'(1));
    rd(5'h08, 0, d);
    check("ps_stuck_status", FLAT'(d), FLAT'(8'h01));
    rd(5'h08, 1, d);
    check("ps_stuck_remain", FLAT'(d), FLAT'(8'h02));
    rd(5'h08, 2, d);
    check("ps_stuck_remain_hi", FLAT'(d), FLAT'(8'h00));
`endif

    // Out-of-range channel, out-of-range bytecnt, unmapped and foreign writes
    wr(5'h00, 0, 8'(NC)); wr(5'h01, 0, 8'd0);
    wr(5'h02, 0, 8'h77);
    rd(5'h02, 0, d);
    check("oor_chan_read", FLAT'(d), FLAT'(8'h00));
    wr(5'h06, 0, 8'h01); tick(); m_commit();
    check_outputs("oor_chan");
    wr(5'h00, 0, 8'd0);
    wr(5'h02, 3, 8'hAA);
    rd(5'h02, 3, d);
    check("oor_byte_read", FLAT'(d), FLAT'(8'h00));
    rd(5'h02, 0, d);
    check("oor_byte_keep", FLAT'(d), FLAT'(m_read(5'h02, 0)));
    wr(5'h1F, 0, 8'h5A);
    rd(5'h1F, 0, d);
    check("unmapped_read", FLAT'(d), FLAT'(8'h00));
    wr_raw(8'h42, 0, 8'hC3);
    rd(5'h02, 0, d);
    check("foreign_write", FLAT'(d), FLAT'(m_read(5'h02, 0)));

    // Randomized shadow traffic with readback and periodic commits
    for (int it = 0; it < 60; it++) begin
      rc = $urandom_range(0, NC);
      rp = $urandom_range(0, NP);
      wr(5'h00, 0, 8'(rc)); wr(5'h01, 0, 8'(rp));
      rsub = 5'($urandom_range(2, 5));
      rb = $urandom_range(0, 3);
      wr(rsub, rb, 8'($urandom));
      rd(rsub, rb, d);
      check("rand_readback", FLAT'(d), FLAT'(m_read(rsub, rb)));
      if (it % 10 == 9) begin
        wr(5'h06, 0, 8'h01); tick(); m_commit();
        check_outputs("rand_commit");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_trigger_bank.md
Name: reg_trigger_bank

Overview:
- Parametrised successor to the main-register trigger controls: multi-channel, multi-pulse trigger timing bank on the USB register bus.
- Host writes shadow registers byte-wise. A commit transfers all shadows to the active outputs in one cycle, deferred while the trigger generator is busy.
- Includes a multi-step trigger-clock phase-shift sequencer (psen/psdone handshake).
- Sits beside the main register block and decodes its own address window.

Parameters:
- pBYTECNT_SIZE, 7, width of reg_bytecnt
- pNUM_CHANNELS, 2, trigger output channels
- pNUM_PULSES, 8, pulses per channel
- pPULSE_SEL_WIDTH, 3, width of pulse index (log2 pNUM_PULSES)
- pTIME_WIDTH, 24, delay/width field bits (multiple of 8)
- pSELECT, 3'b011, value of reg_address[7:5] selecting this block
- pPS_TIMEOUT, 1023, cycles to wait for I_psdone

Ports:
- cwusb_clk  in  1  sole clock
- reset_i  in  1  asynchronous, active-low reset
- reg_address  in  8  register address
- reg_bytecnt  in  pBYTECNT_SIZE  byte index
- write_data  in  8  write byte
- read_data  out  8  read byte, valid one cycle after reg_read
- reg_read  in  1  read strobe
- reg_write  in  1  write strobe
- reg_addrvalid  in  1  address valid
- selected  out  1  reg_addrvalid & reg_address[7:5]==pSELECT
- I_trig_busy  in  1  generator mid-sequence
- O_trigger_delay  out  pNUM_CHANNELS*pNUM_PULSES*pTIME_WIDTH  active delays, channel-major
- O_trigger_width  out  same  active widths
- O_num_pulses  out  pNUM_CHANNELS*4  active pulse counts
- O_chan_enable  out  pNUM_CHANNELS  active enable mask
- O_commit_pulse  out  1  one-cycle strobe on commit
- O_psen  out  1  phase-shift enable pulse
- O_psincdec  out  1  phase-shift direction
- I_psdone  in  1  phase-shift done

Behaviour:
- Reset (reset_i low, async):
  - all shadows, actives, outputs, counters and the commit-pending flag clear to 0;
  - O_num_pulses channels reset to 1;
  - read_data 0.
- Sub-address = reg_address[4:0]; writes act on the reg_write cycle when selected.
- 0x00 CHAN_SEL / 0x01 PULSE_SEL:
  - index registers, 8-bit;
  - out-of-range indices make DELAY/WIDTH accesses no-ops and reads return 0.
- 0x02 DELAY / 0x03 WIDTH:
  - shadow[chan][pulse] byte at reg_bytecnt*8;
  - bytecnt ≥ pTIME_WIDTH/8: write ignored, read 0.
- 0x04 NUM_PULSES: shadow count for CHAN_SEL, 4 bits.
- 0x05 ENABLE: shadow mask.
- 0x06 COMMIT:
  - write bit0=1 sets pending;
  - pending & ~I_trig_busy: next cycle copies all shadows to actives, pulses O_commit_pulse and clears pending;
  - commit write while I_trig_busy=0 → O_commit_pulse 2 cycles after the write;
  - commit write while already pending → no extra commit;
  - write bit0=0 cancels pending;
  - read {6'b0, I_trig_busy, pending}.
- 0x07 PS_STEPS:
  - 16-bit signed, bytes 0–1;
  - writing byte 1 while PS FSM is IDLE loads the count; writes while not IDLE are ignored;
  - 0 does nothing.
- PS FSM:
  - IDLE → ISSUE (count≠0);
  - ISSUE: O_psen=1 for 1 cycle, O_psincdec = (count>0);
  - → WAIT;
  - WAIT on I_psdone: count moves one toward 0; → ISSUE if ≠0, else IDLE.
- 0x08 PS_STATUS read: byte0 {6'b0, timeout, active}; bytes 1–2 remaining count.
- Unmapped sub-addresses: writes ignored, reads 0.
- Simultaneous commit-apply and shadow write in the same cycle: active takes the pre-write shadow value.

Optional Feature:
- Macro: REG_TRIGGER_BANK_PS_TIMEOUT_EN.
- With the macro:
  - WAIT counts cycles; reaching pPS_TIMEOUT without I_psdone → IDLE;
  - sets sticky timeout (status bit1), discards the remaining count;
  - cleared by writing PS_STATUS or by reset.
- Without the macro: WAIT waits indefinitely and the timeout bit reads 0.

Test Plan:
- Reset (reset_i held low 3 cycles) → actives 0, O_num_pulses each 1, O_psen 0, read_data 0.
- Write ch1/pulse2 DELAY bytes 0x56,0x34,0x12 → O_trigger_delay unchanged. Commit with busy=0 → O_trigger_delay[ch1,p2]=0x123456 and single O_commit_pulse 2 cycles after the write.
- Hold I_trig_busy=1, commit → no change, COMMIT reads 0x03. Drop busy → apply next cycle, COMMIT reads 0x00.
- PS_STEPS=-3 (0xFD,0xFF), answer each psen with I_psdone 4 cycles later → exactly 3 psen pulses, psincdec=0, status active 1→0.
- PS_STEPS=+2, a second write mid-sequence, never assert I_psdone:
  - second write ignored;
  - with _EN: one psen, then timeout=1 at pPS_TIMEOUT cycles, remaining count 0;
  - without _EN: stays active.
- CHAN_SEL=pNUM_CHANNELS, write DELAY → no output change, read returns 0. DELAY bytecnt 3 → ignored.
